// File: rtl/btb_file_pkg.sv
// btb_file_pkg: shared encodings, entry field positions and widths for the 2-way BTB.
package btb_file_pkg;
   localparam int NUM_SETS = 8;
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 27;
   localparam int VALID_B = 63;
   localparam int TAG_LO = 36;
   localparam int TGT_LO = 4;
   localparam int ST_LO = 2;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, ST = 2'b10, WT = 2'b11} bp_state_t;
   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} fsm_t;
   function automatic bp_state_t next_state(bp_state_t s, logic taken);
      return taken ? (s == SNT ? WNT : s == WNT ? WT : ST)
                   : (s == ST ? WT : s == WT ? WNT : SNT);
   endfunction
endpackage

// File: rtl/btb_file_if.sv
// btb_file_if: IF read/LRU port, EX update port and flush control of the BTB storage.
interface btb_file_if;
   import btb_file_pkg::*;
   logic [IDX_W-1:0]    rd_index;
   logic [127:0]        rd_set;
   logic [NUM_SETS-1:0] rd_lru;
   logic                lru_wr_en;
   logic                lru_wr_value;
   logic                upd_valid;
   logic [31:0]         upd_pc;
   logic [31:0]         upd_target;
   logic                upd_taken;
   logic                flush_req;
   logic                flush_busy;
   modport master (
      output rd_index, lru_wr_en, lru_wr_value, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
      input  rd_set, rd_lru, flush_busy
   );
   modport slave (
      input  rd_index, lru_wr_en, lru_wr_value, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
      output rd_set, rd_lru, flush_busy
   );
endinterface

// File: rtl/btb_entry_update.sv
// btb_entry_update: next value of one BTB way for a hit update or an allocation.
module btb_entry_update
   import btb_file_pkg::*;
(
   input  logic [63:0]      i_entry,
   input  logic             i_hit,
   input  logic             i_alloc,
   input  logic             i_taken,
   input  logic [TAG_W-1:0] i_tag,
   input  logic [31:0]      i_target,
   output logic [63:0]      o_entry
);
   logic [TAG_W-1:0] w_tag;
   logic [31:0]      w_target;
   bp_state_t        w_state;
   assign w_tag    = i_entry[TAG_LO +: TAG_W];
   assign w_target = i_entry[TGT_LO +: 32];
   assign w_state  = next_state(bp_state_t'(i_entry[ST_LO +: 2]), i_taken);
   assign o_entry  = i_alloc ? {1'b1, i_tag, i_target, WT, 2'b00}
                   : i_hit   ? {1'b1, w_tag, i_taken ? i_target : w_target, w_state, 2'b00}
                   : i_entry;
endmodule

// File: rtl/btb_file.sv
// btb_file: BTB set storage and LRU with single-cycle update RMW and an 8-cycle flush sequencer.
module btb_file
   import btb_file_pkg::*;
(
   input logic       clk,
   input logic       rst_n,
   btb_file_if.slave bus
);
   logic [127:0]        r_set [NUM_SETS];
   logic [NUM_SETS-1:0] r_lru;
   logic [IDX_W-1:0]    r_cnt;
   fsm_t                r_state, w_state_nxt;
   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [63:0]         w_way1, w_way2, w_new1, w_new2;
   logic                w_hit1, w_hit2, w_alloc, w_victim, w_do_upd, w_wr, w_unused_pc;
   assign w_idx       = bus.upd_pc[IDX_W+1:2];
   assign w_tag       = bus.upd_pc[31 -: TAG_W];
   assign w_unused_pc = ^bus.upd_pc[1:0];
   assign w_way1      = r_set[w_idx][127:64];
   assign w_way2      = r_set[w_idx][63:0];
   assign w_hit1      = w_way1[VALID_B] && w_way1[TAG_LO +: TAG_W] == w_tag;
   assign w_hit2      = !w_hit1 && w_way2[VALID_B] && w_way2[TAG_LO +: TAG_W] == w_tag;
   assign w_alloc     = !w_hit1 && !w_hit2 && bus.upd_taken;
   // first invalid way, otherwise whichever way is not the MRU one
   assign w_victim    = !w_way1[VALID_B] ? 1'b0 : !w_way2[VALID_B] ? 1'b1 : !r_lru[w_idx];
   assign w_do_upd    = bus.upd_valid && r_state == IDLE && !bus.flush_req;
   assign w_wr        = w_do_upd && (w_hit1 || w_hit2 || w_alloc);
   btb_entry_update u_way1 (
      .i_entry(w_way1), .i_hit(w_hit1), .i_alloc(w_alloc && !w_victim), .i_taken(bus.upd_taken),
      .i_tag(w_tag), .i_target(bus.upd_target), .o_entry(w_new1)
   );
   btb_entry_update u_way2 (
      .i_entry(w_way2), .i_hit(w_hit2), .i_alloc(w_alloc && w_victim), .i_taken(bus.upd_taken),
      .i_tag(w_tag), .i_target(bus.upd_target), .o_entry(w_new2)
   );
   assign bus.rd_set     = r_state == FLUSH ? '0 : r_set[bus.rd_index];
   assign bus.rd_lru     = r_lru;
   assign bus.flush_busy = r_state == FLUSH;
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = r_state == IDLE ? (bus.flush_req ? FLUSH : IDLE)
                  : (r_cnt == IDX_W'(NUM_SETS - 1) ? IDLE : FLUSH);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SETS; i++) r_set[i] <= '0;
         r_lru <= '0;
         r_cnt <= '0;
      end else if (r_state == IDLE) begin
         if (bus.flush_req) begin
            r_lru <= '0;
            r_cnt <= '0;
         end else begin
            if (bus.lru_wr_en) r_lru[bus.rd_index] <= bus.lru_wr_value;
            // the update's LRU write is later, so it overrides the IF-side write on the same set
            if (w_wr) begin
               r_set[w_idx] <= {w_new1, w_new2};
               r_lru[w_idx] <= w_hit2 || (w_alloc && w_victim);
            end
         end
      end else begin
         r_set[r_cnt] <= '0;
         r_cnt        <= r_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_btb_file.sv
// tb_btb_file: randomized and directed checks of btb_file against a field-level reference model.
module tb_btb_file;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   btb_file_if bus();
   btb_file u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_cmp = 0;
   int n_err = 0;
   // model: per-way fields; strength 0..3 orders SNT < WNT < WT < ST
   bit          m_v   [8][2];
   logic [26:0] m_tag [8][2];
   logic [31:0] m_tgt [8][2];
   int          m_str [8][2];
   bit          m_lru [8];
   function automatic logic [1:0] enc(int s);
      return s == 0 ? 2'b00 : s == 1 ? 2'b01 : s == 2 ? 2'b11 : 2'b10;
   endfunction
   function automatic logic [63:0] m_entry(int i, int w);
      return m_v[i][w] ? {1'b1, m_tag[i][w], m_tgt[i][w], enc(m_str[i][w]), 2'b00} : 64'h0;
   endfunction
   function automatic logic [127:0] m_set(int i);
      return {m_entry(i, 0), m_entry(i, 1)};
   endfunction
   function automatic logic [7:0] m_lruv();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_lru[i];
      return v;
   endfunction
   task automatic m_clear();
      for (int i = 0; i < 8; i++) begin
         m_lru[i] = 0;
         for (int w = 0; w < 2; w++) begin
            m_v[i][w] = 0; m_tag[i][w] = '0; m_tgt[i][w] = '0; m_str[i][w] = 0;
         end
      end
   endtask
   task automatic m_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
      int i, w;
      logic [26:0] t;
      i = int'(pc[4:2]);
      t = pc[31:5];
      w = -1;
      for (int k = 1; k >= 0; k--) if (m_v[i][k] && m_tag[i][k] == t) w = k;
      if (w >= 0) begin
         m_str[i][w] = tk ? (m_str[i][w] == 3 ? 3 : m_str[i][w] + 1) : (m_str[i][w] == 0 ? 0 : m_str[i][w] - 1);
         if (tk) m_tgt[i][w] = tgt;
         m_lru[i] = (w == 1);
      end else if (tk) begin
         w = !m_v[i][0] ? 0 : !m_v[i][1] ? 1 : (m_lru[i] ? 0 : 1);
         m_v[i][w] = 1; m_tag[i][w] = t; m_tgt[i][w] = tgt; m_str[i][w] = 2;
         m_lru[i] = (w == 1);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bus.rd_index = '0; bus.lru_wr_en = 0; bus.lru_wr_value = 0; bus.upd_valid = 0;
      bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 0; bus.flush_req = 0;
   endtask
   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      m_clear();
   endtask
   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
      bus.upd_pc = pc; bus.upd_target = tgt; bus.upd_taken = tk; bus.upd_valid = 1;
      tick();
      bus.upd_valid = 0;
      m_upd(pc, tgt, tk);
   endtask
   task automatic fill();
      for (int i = 0; i < 8; i++)
         for (int w = 0; w < 2; w++)
            upd({27'(27'h100 + i * 2 + w), 3'(i), 2'b00}, $urandom, 1);
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         bus.rd_index = 3'(i);
         #1;
         n_cmp++;
         if (bus.rd_set !== 128'h0) begin n_err++; $display("FAIL reset_set[%0d]: got %h want 0", i, bus.rd_set); end
      end
      n_cmp++;
      if (bus.rd_lru !== 8'h0) begin n_err++; $display("FAIL reset_lru: got %h want 00", bus.rd_lru); end
      n_cmp++;
      if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.flush_busy); end
   endtask

   task automatic test_alloc();
      logic [63:0] exp;
      exp = {1'b1, 27'h80, 32'h2000, 2'b11, 2'b00};
      upd(32'h0000_1004, 32'h2000, 1);
      bus.rd_index = 3'd1;
      #1;
      n_cmp++;
      if (bus.rd_set[127:64] !== exp) begin n_err++; $display("FAIL alloc_way1: got %h want %h", bus.rd_set[127:64], exp); end
      n_cmp++;
      if (bus.rd_set !== m_set(1)) begin n_err++; $display("FAIL alloc_set: got %h want %h", bus.rd_set, m_set(1)); end
      n_cmp++;
      if (bus.rd_lru[1] !== 1'b0) begin n_err++; $display("FAIL alloc_lru: got %b want 0", bus.rd_lru[1]); end
   endtask

   task automatic test_saturation();
      bit          tk  [6] = '{1, 1, 0, 0, 0, 0};
      logic [1:0]  est [6] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
      logic [63:0] way;
      bus.rd_index = 3'd1;
      for (int k = 0; k < 6; k++) begin
         upd(32'h0000_1004, 32'h3000 + 32'(k * 16), tk[k]);
         way = bus.rd_set[127:64];
         n_cmp++;
         if (way[3:2] !== est[k]) begin n_err++; $display("FAIL sat_state[%0d]: got %b want %b", k, way[3:2], est[k]); end
         n_cmp++;
         if (bus.rd_set !== m_set(1)) begin n_err++; $display("FAIL sat_set[%0d]: got %h want %h", k, bus.rd_set, m_set(1)); end
      end
   endtask

   task automatic test_victim();
      logic [63:0] w1, w2;
      do_reset();
      bus.rd_index = 3'd1;
      upd(32'h0000_1004, 32'hA000, 1);
      upd(32'h0000_2004, 32'hB000, 1);
      n_cmp++;
      if (bus.rd_lru[1] !== 1'b1) begin n_err++; $display("FAIL victim_lru_fill: got %b want 1", bus.rd_lru[1]); end
      upd(32'h0000_1004, 32'hA100, 1);
      n_cmp++;
      if (bus.rd_lru[1] !== 1'b0) begin n_err++; $display("FAIL victim_lru_hit: got %b want 0", bus.rd_lru[1]); end
      upd(32'h0000_3004, 32'hC000, 1);
      w1 = bus.rd_set[127:64];
      w2 = bus.rd_set[63:0];
      n_cmp++;
      if (w2[62:36] !== 27'h180) begin n_err++; $display("FAIL victim_way2_tag: got %h want 180", w2[62:36]); end
      n_cmp++;
      if (w1[62:36] !== 27'h80) begin n_err++; $display("FAIL victim_way1_tag: got %h want 80", w1[62:36]); end
      n_cmp++;
      if (bus.rd_lru[1] !== 1'b1) begin n_err++; $display("FAIL victim_lru_alloc: got %b want 1", bus.rd_lru[1]); end
      n_cmp++;
      if (bus.rd_set !== m_set(1)) begin n_err++; $display("FAIL victim_set: got %h want %h", bus.rd_set, m_set(1)); end
   endtask

   task automatic test_lru_collision();
      bus.rd_index = 3'd1; bus.lru_wr_en = 1; bus.lru_wr_value = 0;
      bus.upd_pc = 32'h0000_3004; bus.upd_target = 32'hC100; bus.upd_taken = 1; bus.upd_valid = 1;
      tick();
      bus.lru_wr_en = 0; bus.upd_valid = 0;
      m_lru[1] = 0;
      m_upd(32'h0000_3004, 32'hC100, 1);
      n_cmp++;
      if (bus.rd_lru[1] !== 1'b1) begin n_err++; $display("FAIL lru_same_idx: got %b want 1", bus.rd_lru[1]); end
      bus.rd_index = 3'd2; bus.lru_wr_en = 1; bus.lru_wr_value = 1;
      bus.upd_pc = 32'h0000_1004; bus.upd_target = 32'hA200; bus.upd_taken = 0; bus.upd_valid = 1;
      tick();
      bus.lru_wr_en = 0; bus.upd_valid = 0;
      m_lru[2] = 1;
      m_upd(32'h0000_1004, 32'hA200, 0);
      n_cmp++;
      if (bus.rd_lru !== m_lruv()) begin n_err++; $display("FAIL lru_diff_idx: got %h want %h", bus.rd_lru, m_lruv()); end
      n_cmp++;
      if (bus.rd_lru[2:1] !== 2'b10) begin n_err++; $display("FAIL lru_diff_bits: got %b want 10", bus.rd_lru[2:1]); end
   endtask

   task automatic test_random();
      logic [26:0] t;
      int idx;
      for (int n = 0; n < 300; n++) begin
         t = 27'($urandom_range(1, 3)) * 27'h5a5;
         bus.rd_index = 3'($urandom_range(0, 7));
         bus.lru_wr_en = ($urandom % 3) == 0;
         bus.lru_wr_value = 1'($urandom);
         bus.upd_valid = 1'($urandom);
         bus.upd_pc = {t, 3'($urandom_range(0, 3)), 2'($urandom)};
         bus.upd_target = $urandom;
         bus.upd_taken = ($urandom % 4) != 0;
         tick();
         if (bus.lru_wr_en) m_lru[bus.rd_index] = bus.lru_wr_value;
         if (bus.upd_valid) m_upd(bus.upd_pc, bus.upd_target, bus.upd_taken);
         bus.lru_wr_en = 0; bus.upd_valid = 0;
         idx = int'(bus.rd_index);
         n_cmp++;
         if (bus.rd_set !== m_set(idx)) begin n_err++; $display("FAIL rand_set[%0d] cyc %0d: got %h want %h", idx, n, bus.rd_set, m_set(idx)); end
         n_cmp++;
         if (bus.rd_lru !== m_lruv()) begin n_err++; $display("FAIL rand_lru cyc %0d: got %h want %h", n, bus.rd_lru, m_lruv()); end
      end
   endtask

   task automatic test_flush();
      fill();
      bus.flush_req = 1; bus.upd_valid = 1;
      bus.upd_pc = 32'h0AB0_0004; bus.upd_target = 32'h1234; bus.upd_taken = 1;
      tick();
      m_clear();
      bus.rd_index = 3'd7;
      for (int c = 0; c < 8; c++) begin
         bus.flush_req = 0; bus.upd_valid = 0; bus.lru_wr_en = 0;
         #1;
         n_cmp++;
         if (bus.flush_busy !== 1'b1) begin n_err++; $display("FAIL flush_busy[%0d]: got %b want 1", c, bus.flush_busy); end
         n_cmp++;
         if (bus.rd_set !== 128'h0) begin n_err++; $display("FAIL flush_rdset[%0d]: got %h want 0", c, bus.rd_set); end
         bus.flush_req = 1; bus.upd_valid = 1; bus.lru_wr_en = 1; bus.lru_wr_value = 1;
         bus.upd_pc = {27'h7000 + 27'(c), 3'(c), 2'b00}; bus.upd_target = $urandom; bus.upd_taken = 1;
         @(posedge clk);
      end
      #1;
      idle_inputs();
      n_cmp++;
      if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL flush_done: got %b want 0", bus.flush_busy); end
      n_cmp++;
      if (bus.rd_lru !== m_lruv()) begin n_err++; $display("FAIL flush_lru: got %h want %h", bus.rd_lru, m_lruv()); end
      for (int i = 0; i < 8; i++) begin
         bus.rd_index = 3'(i);
         #1;
         n_cmp++;
         if (bus.rd_set !== m_set(i)) begin n_err++; $display("FAIL flush_set[%0d]: got %h want %h", i, bus.rd_set, m_set(i)); end
      end
   endtask

   task automatic test_flush_reset();
      fill();
      bus.flush_req = 1;
      tick();
      bus.flush_req = 0;
      repeat (2) tick();
      rst_n = 0;
      m_clear();
      #1;
      n_cmp++;
      if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL rstflush_busy: got %b want 0", bus.flush_busy); end
      n_cmp++;
      if (bus.rd_lru !== 8'h0) begin n_err++; $display("FAIL rstflush_lru: got %h want 00", bus.rd_lru); end
      for (int i = 0; i < 8; i++) begin
         bus.rd_index = 3'(i);
         #1;
         n_cmp++;
         if (bus.rd_set !== 128'h0) begin n_err++; $display("FAIL rstflush_set[%0d]: got %h want 0", i, bus.rd_set); end
      end
      @(negedge clk);
      rst_n = 1;
      repeat (3) tick();
      n_cmp++;
      if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL rstflush_resume: got %b want 0", bus.flush_busy); end
      bus.rd_index = 3'd7;
      #1;
      n_cmp++;
      if (bus.rd_set !== m_set(7)) begin n_err++; $display("FAIL rstflush_after: got %h want %h", bus.rd_set, m_set(7)); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alloc();
      test_saturation();
      test_victim();
      test_lru_collision();
      test_random();
      test_flush();
      test_flush_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
